// File: rtl/prbs_pkg.sv
// Shared types and per-polynomial constants for the PRBS checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    POLY_7  = 2'd0,
    POLY_15 = 2'd1,
    POLY_23 = 2'd2,
    POLY_31 = 2'd3
  } poly_e;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int LFSR_W = 31;

  // Polynomial order: number of bits needed to fill the seed.
  localparam logic [4:0] POLY_ORDER  [0:3] = '{5'd7, 5'd15, 5'd23, 5'd31};
  // LFSR bit indices XORed to form the predicted bit (S[0] = newest bit).
  localparam logic [4:0] POLY_TAP_HI [0:3] = '{5'd6, 5'd14, 5'd22, 5'd30};
  localparam logic [4:0] POLY_TAP_LO [0:3] = '{5'd5, 5'd13, 5'd17, 5'd27};

endpackage

// File: rtl/prbs_lfsr_pred.sv
// Receive-side LFSR: shift register of past decided bits plus the tap mux
// that predicts the next incoming bit for the selected polynomial.
module prbs_lfsr_pred
  import prbs_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  shift_en,
  input  logic  shift_in,
  input  poly_e poly,
  output logic  pred
);

  logic [LFSR_W-1:0] lfsr;

  // Shift in the decided bit on every qualified input bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= '0;
    end else if (shift_en) begin
      lfsr <= {lfsr[LFSR_W-2:0], shift_in};
    end
  end

  assign pred = lfsr[POLY_TAP_HI[poly]] ^ lfsr[POLY_TAP_LO[poly]];

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: seeds a local LFSR from the received stream, verifies it,
// then free-runs and counts bit errors; periodic snapshots of the counts.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_SEED   | loading the LFSR with the first N received bits
// ST_VERIFY | comparing received bits against prediction, counting matches
// ST_LOCKED | LFSR free-running, counting total and errored bits
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int SNAP_INTERVAL = 100_000_000,
  parameter int LOCK_MATCHES  = 16,
  parameter int LOL_WINDOW    = 1024,
  parameter int LOL_THRESH    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic [1:0]       poly_sel,
  input  logic             resync,
  input  logic             snap_ack,
  output logic             snap_valid,
  output logic [CNT_W-1:0] error_bits_out,
  output logic [CNT_W-1:0] total_bits_out,
  output logic             locked,
  output logic             lol_pulse,
  output logic             snap_overrun
);

  localparam int TMR_W   = (SNAP_INTERVAL > 1) ? $clog2(SNAP_INTERVAL) : 1;
  localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam int WBIT_W  = $clog2(LOL_WINDOW + 1);
  localparam int WERR_W  = $clog2(LOL_THRESH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state, state_nxt;
  logic [4:0]         seed_cnt, seed_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic [WBIT_W-1:0]  win_bits, wbits_nxt;
  logic [WERR_W-1:0]  win_err, werr_nxt;
  logic [CNT_W-1:0]   err_cnt, err_nxt;
  logic [CNT_W-1:0]   tot_cnt, tot_nxt;
  logic [1:0]         poly_q;
  logic               lol_nxt;
  logic [TMR_W-1:0]   snap_tmr;

  poly_e poly_cur;
  logic  restart, pred, shift_in, mismatch, snap_tc;

  assign poly_cur = poly_e'(poly_sel);
  assign restart  = resync | (poly_sel != poly_q);
  // Once locked the LFSR feeds back its own prediction, so input errors
  // cannot corrupt the reference sequence.
  assign shift_in = (state == ST_LOCKED) ? pred : bit_in;
  assign mismatch = bit_in ^ pred;
  assign locked   = (state == ST_LOCKED);
  assign snap_tc  = (snap_tmr == TMR_W'(SNAP_INTERVAL - 1));

  prbs_lfsr_pred u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (bit_valid),
    .shift_in (shift_in),
    .poly     (poly_cur),
    .pred     (pred)
  );

  // Next state, lock/window bookkeeping and saturating bit counters.
  always_comb begin
    state_nxt = state;
    seed_nxt  = seed_cnt;
    match_nxt = match_cnt;
    wbits_nxt = win_bits;
    werr_nxt  = win_err;
    err_nxt   = err_cnt;
    tot_nxt   = tot_cnt;
    lol_nxt   = 1'b0;
    if (restart) begin
      state_nxt = ST_SEED;
      seed_nxt  = '0;
      match_nxt = '0;
      wbits_nxt = '0;
      werr_nxt  = '0;
      err_nxt   = '0;
      tot_nxt   = '0;
      lol_nxt   = (state == ST_LOCKED);
    end else if (bit_valid) begin
      case (state)
        ST_SEED: begin
          if (seed_cnt == POLY_ORDER[poly_cur] - 5'd1) begin
            state_nxt = ST_VERIFY;
            seed_nxt  = '0;
            match_nxt = '0;
          end else begin
            seed_nxt = seed_cnt + 5'd1;
          end
        end
        ST_VERIFY: begin
          if (mismatch) begin
            state_nxt = ST_SEED;
            seed_nxt  = '0;
            match_nxt = '0;
          end else if (match_cnt == MATCH_W'(LOCK_MATCHES - 1)) begin
            state_nxt = ST_LOCKED;
            match_nxt = '0;
            wbits_nxt = '0;
            werr_nxt  = '0;
          end else begin
            match_nxt = match_cnt + MATCH_W'(1);
          end
        end
        ST_LOCKED: begin
          if (tot_cnt != CNT_MAX) tot_nxt = tot_cnt + CNT_W'(1);
          if (mismatch && (err_cnt != CNT_MAX)) err_nxt = err_cnt + CNT_W'(1);
          if (mismatch && (win_err == WERR_W'(LOL_THRESH - 1))) begin
            state_nxt = ST_SEED;
            seed_nxt  = '0;
            wbits_nxt = '0;
            werr_nxt  = '0;
            err_nxt   = '0;
            tot_nxt   = '0;
            lol_nxt   = 1'b1;
          end else if (win_bits == WBIT_W'(LOL_WINDOW - 1)) begin
            wbits_nxt = '0;
            werr_nxt  = '0;
          end else begin
            wbits_nxt = win_bits + WBIT_W'(1);
            werr_nxt  = win_err + WERR_W'(mismatch);
          end
        end
        default: state_nxt = ST_SEED;
      endcase
    end
  end

  // FSM state, counters, polynomial-change reference and loss-of-lock pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SEED;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_err   <= '0;
      err_cnt   <= '0;
      tot_cnt   <= '0;
      poly_q    <= '0;
      lol_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      seed_cnt  <= seed_nxt;
      match_cnt <= match_nxt;
      win_bits  <= wbits_nxt;
      win_err   <= werr_nxt;
      err_cnt   <= err_nxt;
      tot_cnt   <= tot_nxt;
      poly_q    <= poly_sel;
      lol_pulse <= lol_nxt;
    end
  end

  // Free-running snapshot timer and snapshot output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_tmr       <= '0;
      snap_valid     <= 1'b0;
      snap_overrun   <= 1'b0;
      error_bits_out <= '0;
      total_bits_out <= '0;
    end else begin
      snap_tmr <= snap_tc ? '0 : snap_tmr + TMR_W'(1);
      if (snap_tc) begin
        error_bits_out <= err_cnt;
        total_bits_out <= tot_cnt;
        snap_valid     <= 1'b1;
        if (snap_valid && !snap_ack) snap_overrun <= 1'b1;
      end else if (snap_ack) begin
        snap_valid <= 1'b0;
      end
    end
  end

endmodule
